// File: rtl/mxrv_csr_access.sv
// mxrv_csr_access: Zicsr read-modify-write sequencer on the shared CSR file port.
// Define CSR_RDONLY_CHK_EN to trap writes into the read-only CSR space (addr[11:10]==2'b11).
module mxrv_csr_access #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        rd_idx_i,
    input  logic [4:0]        rs1_idx_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [ADDR_W-1:0] csr_addr_i,
    input  logic              kill_i,
    output logic [ADDR_W-1:0] csr_addr_o,
    output logic              csr_we_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    input  logic [DATA_W-1:0] csr_rdata_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [4:0]        wb_rd_o,
    output logic              wb_we_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              illegal_o,
    output logic              retire_o
);
`ifdef CSR_RDONLY_CHK_EN
    localparam bit RO_CHK = 1'b1;
`else
    localparam bit RO_CHK = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP} state_t;
    state_t state, state_nx;
    logic [1:0]        op_q;
    logic [4:0]        rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] opv_q, old_q, new_val, in_op;
    logic              ill_q, skip_wr_q;
    logic              in_rw, in_bad, in_wr, in_ro, accept;
    assign in_op  = funct3_i[2] ? DATA_W'(rs1_idx_i) : rs1_data_i;
    assign in_rw  = funct3_i[1:0] == 2'b01;
    assign in_bad = funct3_i[1:0] == 2'b00;
    assign in_wr  = in_rw | (rs1_idx_i != 5'd0);
    assign in_ro  = RO_CHK & in_wr & (csr_addr_i[ADDR_W-1 -: 2] == 2'b11);
    assign accept = start_i & (state == IDLE);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            addr_q    <= '0;
            opv_q     <= '0;
            old_q     <= '0;
            ill_q     <= 1'b0;
            skip_wr_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q      <= funct3_i[1:0];
                rd_q      <= rd_idx_i;
                addr_q    <= csr_addr_i;
                opv_q     <= in_op;
                old_q     <= '0;
                ill_q     <= in_bad | in_ro;
                skip_wr_q <= !in_wr;
            end
            if (state == CAPT) old_q <= csr_rdata_i;
        end
    end
    // Illegal funct3 and a read-free trapped write both answer immediately
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = in_bad ? RESP : (in_rw && rd_idx_i == 5'd0) ? (in_ro ? RESP : WRITE) : READ;
            READ:    state_nx = kill_i ? IDLE : CAPT;
            CAPT:    state_nx = kill_i ? IDLE : (skip_wr_q | ill_q) ? RESP : WRITE;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = wb_ready_i ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    assign new_val     = op_q == 2'b01 ? opv_q : op_q == 2'b10 ? (old_q | opv_q) : (old_q & ~opv_q);
    assign ready_o     = state == IDLE;
    assign csr_addr_o  = state == IDLE ? '0 : addr_q;
    assign csr_we_o    = state == WRITE;
    assign csr_wdata_o = state == WRITE ? new_val : '0;
    assign wb_valid_o  = state == RESP;
    assign wb_rd_o     = rd_q;
    assign wb_we_o     = wb_valid_o & (rd_q != 5'd0) & !ill_q;
    assign wb_data_o   = wb_valid_o ? old_q : '0;
    assign illegal_o   = wb_valid_o & ill_q;
    assign retire_o    = wb_valid_o & wb_ready_i;
endmodule

// File: doc/mxrv_csr_access.md
Name: mxrv_csr_access

Overview:
- Initiator side of the CSR register-file read/write port.
- Accepts one decoded Zicsr instruction (CSRRW/RS/RC and immediate forms) from execute.
- Sequences read-old-value, then modify, then write-new-value over the single shared addr/we/wdata/rdata port, whose read data arrives one cycle late.
- Returns the old CSR value to writeback and pulses a retire strobe that feeds the instret counter.

Parameters:
ADDR_W, 12, CSR address width
DATA_W, 32, CSR/GPR data width

Ports:
clk  input  1  clock
rst_n  input  1  reset
start_i  input  1  instruction valid; accepted when start_i & ready_o
ready_o  output  1  high only in IDLE
funct3_i  input  3  Zicsr funct3
rd_idx_i  input  5  destination GPR index
rs1_idx_i  input  5  rs1 index / uimm
rs1_data_i  input  DATA_W  rs1 value
csr_addr_i  input  ADDR_W  target CSR address
kill_i  input  1  pipeline flush
csr_addr_o  output  ADDR_W  to CSR file address
csr_we_o  output  1  1 = write, 0 = read
csr_wdata_o  output  DATA_W  CSR write data
csr_rdata_i  input  DATA_W  CSR read data, registered, valid the cycle after addr is presented with we=0
wb_valid_o  output  1  response valid
wb_ready_i  input  1  writeback accepts
wb_rd_o  output  5  destination index
wb_we_o  output  1  GPR write enable
wb_data_o  output  DATA_W  old CSR value
illegal_o  output  1  illegal-instruction flag, qualified by wb_valid_o
retire_o  output  1  one-cycle pulse on wb_valid_o & wb_ready_i

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: FSM in IDLE. All outputs 0 except ready_o=1. Internal latches are cleared.
- Accept: on start_i & ready_o, latch funct3, rd, rs1 idx/data and addr.
- Operand:
  - funct3[2]=1: op = zero-extended 5-bit uimm (rs1_idx_i).
  - funct3[2]=0: op = rs1_data_i.
- New value:
  - RW: new = op.
  - RS: new = old | op.
  - RC: new = old & ~op.
- funct3 000 or 100 is illegal. Go straight to RESP with illegal_o=1, wb_we_o=0, wb_data_o=0, and no CSR access.
- States:
  - IDLE: csr_addr_o=0, csr_we_o=0.
  - READ: csr_addr_o=latched addr, csr_we_o=0.
  - CAPT: capture csr_rdata_i into old.
  - WRITE: csr_we_o=1 for exactly one cycle, csr_wdata_o=new.
  - RESP: wb_valid_o=1, held until wb_ready_i.
  - csr_addr_o holds the latched addr in every state except IDLE.
- Normal path: IDLE to READ, READ to CAPT, CAPT to WRITE, WRITE to RESP, RESP to IDLE on wb_ready_i. First wb_valid_o is 4 cycles after accept.
- Skip read: RW/RWI with rd=0 goes IDLE to WRITE directly. No read cycle is issued; wb_data_o=0 and wb_we_o=0.
- Skip write: RS/RC/RSI/RCI with rs1 idx=0 goes CAPT to RESP. csr_we_o is never asserted.
- wb_we_o = (rd != 0) and not illegal. wb_rd_o = latched rd.
- wb_valid_o and wb_data_o stay stable while wb_ready_i=0.
- kill_i:
  - In READ or CAPT: return to IDLE next cycle, with no write, no response and no retire.
  - In WRITE or RESP: ignored, because the write is committed.
- Simultaneous wb_ready_i in RESP and start_i: start_i is not accepted that cycle; ready_o rises the next cycle.
- Reset asserted mid-operation: immediate IDLE with outputs at reset values. A pending write is dropped if reset arrives before its edge.

Optional Feature:
- Macro: CSR_RDONLY_CHK_EN.
- Defined: an address with addr[11:10]==2'b11 (read-only space) is checked when a write would occur (RW/RWI always; RS/RC when rs1 idx != 0).
  - On such a write, suppress the WRITE state, set illegal_o=1 and wb_we_o=0.
  - The read still occurs unless it is skipped.
- Undefined: no check. The write is issued to the CSR file, which ignores it, and illegal_o reflects only bad funct3.

Test Plan:
- CSRRW 0x340, old 0xA5A5A5A5, rs1=0x12345678, rd=5 -> read in cycle 1, write 0x12345678 in cycle 3, wb_valid in cycle 4 with wb_data=0xA5A5A5A5, wb_rd=5, wb_we=1, retire pulse.
- CSRRS 0x300, old 0x08, rs1 idx 3 = 0x80 -> write 0x88; then CSRRC with rs1 data 0x08 -> write 0x80, wb_data=0x88.
- CSRRSI 0x305, uimm=0 -> csr_we_o never 1, wb_data=old value, response in cycle 3.
- CSRRWI 0x305, rd=0, uimm=0x1F -> no read cycle, csr_wdata=0x0000001F in cycle 1, wb_valid in cycle 2 with wb_we=0; hold wb_ready=0 for 3 cycles -> outputs stable.
- CSRRW 0xF14, rs1=0xFF -> with macro: no write, illegal_o=1, wb_we=0; without macro: write of 0xFF issued, illegal_o=0.
- kill_i in CAPT -> no write, no wb_valid, ready_o=1 next cycle; rst_n low during WRITE -> all outputs 0 asynchronously, ready_o=1.
